// File: rtl/prio_table_ctrl.sv
// rtl/prio_table_ctrl.sv - buffered weight-table update controller for a priority arbiter
module prio_table_ctrl #(
    parameter int NUM_REQ    = 32,
    parameter int PRIO_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DEFER      = 0,
    parameter int RESET_PRIO = 1,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRIO_W-1:0]         prio,
    input  logic [ID_W-1:0]           prio_id,
    input  logic                      prio_upt,
    output logic                      prio_rdy,
    input  logic                      epoch,
    input  logic                      err_clr,
    output logic [NUM_REQ*PRIO_W-1:0] prio_vec,
    output logic                      upt_done,
    output logic                      upt_err,
    output logic [CNT_W-1:0]          pend_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ID_W + PRIO_W;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  drain_cnt;
    logic              accept;
    logic              id_ok;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [ID_W-1:0]   head_id;
    logic [PRIO_W-1:0] head_prio;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full slot.
    assign prio_rdy  = rst && (count < CNT_W'(FIFO_DEPTH));
    assign id_ok     = ({1'b0, prio_id} < (ID_W + 1)'(NUM_REQ));
    assign accept    = prio_upt && prio_rdy;
    assign push      = accept && id_ok;
    assign pop       = (DEFER == 0) ? (count != '0) : (state == DRAIN);
    assign head      = mem[rd_ptr];
    assign head_id   = head[ENT_W-1:PRIO_W];
    assign head_prio = head[PRIO_W-1:0];
    assign pend_cnt  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {prio_id, prio};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                prio_vec[i*PRIO_W +: PRIO_W] <= PRIO_W'(RESET_PRIO);
            end
            upt_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pop && head_id == ID_W'(i)) begin
                    prio_vec[i*PRIO_W +: PRIO_W] <= head_prio;
                end
            end
            upt_done <= pop;
        end
    end

    // A new bad id in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            upt_err <= 1'b0;
        end else if (accept && !id_ok) begin
            upt_err <= 1'b1;
        end else if (err_clr) begin
            upt_err <= 1'b0;
        end
    end

    // Deferred mode drains only the entries that were queued when the epoch arrived.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else if (DEFER != 0) begin
            case (state)
                IDLE: begin
                    if (epoch && count != '0) begin
                        state     <= DRAIN;
                        drain_cnt <= count;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_W'(1);
                    if (drain_cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_table_ctrl.sv
// tb/tb_prio_table_ctrl.sv - randomized and directed checks of prio_table_ctrl against a queue model
module tb_prio_table_ctrl;

    logic         clk;
    logic         rst;

    logic [3:0]   a_prio;
    logic [4:0]   a_id;
    logic         a_upt, a_epoch, a_clr;
    logic         a_rdy, a_done, a_err;
    logic [127:0] a_vec;
    logic [2:0]   a_cnt;

    logic [3:0]   b_prio;
    logic [4:0]   b_id;
    logic         b_upt, b_epoch, b_clr;
    logic         b_rdy, b_done, b_err;
    logic [79:0]  b_vec;
    logic [2:0]   b_cnt;

    int checks;
    int errors;

    int am_w [32];
    int bm_w [20];
    int aq [$];
    int bq [$];
    int b_left;
    bit am_done, am_err, bm_done, bm_err;
    bit a_acc, b_acc;

    prio_table_ctrl #(
        .NUM_REQ(32), .PRIO_W(4), .FIFO_DEPTH(4), .DEFER(0), .RESET_PRIO(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .prio(a_prio), .prio_id(a_id), .prio_upt(a_upt),
        .prio_rdy(a_rdy), .epoch(a_epoch), .err_clr(a_clr), .prio_vec(a_vec),
        .upt_done(a_done), .upt_err(a_err), .pend_cnt(a_cnt)
    );

    prio_table_ctrl #(
        .NUM_REQ(20), .PRIO_W(4), .FIFO_DEPTH(4), .DEFER(1), .RESET_PRIO(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .prio(b_prio), .prio_id(b_id), .prio_upt(b_upt),
        .prio_rdy(b_rdy), .epoch(b_epoch), .err_clr(b_clr), .prio_vec(b_vec),
        .upt_done(b_done), .upt_err(b_err), .pend_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: inputs already driven at the falling edge, model advanced after the rising edge.
    task automatic tick();
        logic [127:0] ev;
        int e;
        #1;
        check("a_rdy", a_rdy, rst && aq.size() < 4);
        check("b_rdy", b_rdy, rst && bq.size() < 4);
        a_acc = a_upt && rst && aq.size() < 4;
        b_acc = b_upt && rst && bq.size() < 4;
        @(posedge clk);
        #1;
        if (!rst) begin
            foreach (am_w[i]) am_w[i] = 1;
            foreach (bm_w[i]) bm_w[i] = 1;
            aq.delete();
            bq.delete();
            b_left  = 0;
            am_done = 0; am_err = 0;
            bm_done = 0; bm_err = 0;
        end else begin
            am_done = 0;
            if (aq.size() > 0) begin
                e = aq.pop_front();
                am_w[e / 16] = e % 16;
                am_done = 1;
            end
            if (a_acc && a_id < 32) aq.push_back(a_id * 16 + a_prio);
            if (a_acc && a_id >= 32) am_err = 1;
            else if (a_clr) am_err = 0;

            bm_done = 0;
            if (b_left > 0) begin
                e = bq.pop_front();
                bm_w[e / 16] = e % 16;
                bm_done = 1;
                b_left--;
            end else if (b_epoch && bq.size() > 0) begin
                b_left = bq.size();
            end
            if (b_acc && b_id < 20) bq.push_back(b_id * 16 + b_prio);
            if (b_acc && b_id >= 20) bm_err = 1;
            else if (b_clr) bm_err = 0;
        end
        ev = '0;
        foreach (am_w[i]) ev[i*4 +: 4] = am_w[i][3:0];
        check("a_vec", a_vec, ev);
        check("a_done", a_done, am_done);
        check("a_err", a_err, am_err);
        check("a_cnt", a_cnt, aq.size());
        ev = '0;
        foreach (bm_w[i]) ev[i*4 +: 4] = bm_w[i][3:0];
        check("b_vec", b_vec, ev);
        check("b_done", b_done, bm_done);
        check("b_err", b_err, bm_err);
        check("b_cnt", b_cnt, bq.size());
        @(negedge clk);
    endtask

    task automatic b_push(input int id, input int p);
        b_upt = 1; b_id = 5'(id); b_prio = 4'(p);
        tick();
        b_upt = 0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 0;
        {a_prio, a_id, a_upt, a_epoch, a_clr} = '0;
        {b_prio, b_id, b_upt, b_epoch, b_clr} = '0;
        foreach (am_w[i]) am_w[i] = 1;
        foreach (bm_w[i]) bm_w[i] = 1;
        b_left = 0;
        @(negedge clk);
        tick();
        tick();
        check("rst_rdy", a_rdy, 1'b0);
        rst = 1;
        tick();
        check("rst_vec", b_vec, {20{4'h1}});

        // single update lands one cycle after acceptance
        a_upt = 1; a_id = 5; a_prio = 9;
        tick();
        a_upt = 0;
        tick();
        check("a_id5", a_vec[23:20], 4'd9);
        check("a_done5", a_done, 1'b1);

        // back-to-back writes to one id: last wins
        a_upt = 1; a_id = 3; a_prio = 2;
        tick();
        a_prio = 11;
        tick();
        a_upt = 0;
        tick();
        tick();
        check("a_id3", a_vec[15:12], 4'd11);

        // deferred: fill the buffer, nothing applied until epoch
        for (int i = 0; i < 4; i++) b_push(i, 7);
        check("b_full_cnt", b_cnt, 3'd4);
        check("b_full_rdy", b_rdy, 1'b0);
        b_epoch = 1;
        tick();
        b_epoch = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("b_drain_cnt", b_cnt, 3'(4 - k));
        end
        check("b_ids0_3", b_vec[15:0], 16'h7777);

        // entry accepted mid-drain waits for the next epoch
        b_push(4, 3);
        b_push(5, 12);
        b_epoch = 1;
        tick();
        b_epoch = 0;
        b_push(6, 9);
        tick();
        tick();
        check("b_late_cnt", b_cnt, 3'd1);
        check("b_late_hold", b_vec[27:24], 4'd1);
        b_epoch = 1;
        tick();
        b_epoch = 0;
        tick();
        check("b_late_apply", b_vec[27:24], 4'd9);

        // out-of-range id: sticky error, clear, and clear losing to a new error
        b_push(25, 4);
        check("b_err_set", b_err, 1'b1);
        tick();
        b_clr = 1;
        tick();
        check("b_err_clr", b_err, 1'b0);
        b_push(30, 4);
        b_clr = 0;
        check("b_err_win", b_err, 1'b1);
        check("b_err_noenq", b_cnt, 3'd0);

        // reset in the middle of a drain discards everything
        for (int i = 7; i < 10; i++) b_push(i, 5);
        b_epoch = 1;
        tick();
        b_epoch = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        check("b_rst_cnt", b_cnt, 3'd0);
        check("b_rst_vec", b_vec, {20{4'h1}});
        for (int i = 0; i < 3; i++) tick();
        check("b_rst_quiet", b_done, 1'b0);

        // randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 149) != 0);
            a_upt   = $urandom_range(0, 2) != 0;
            a_id    = 5'($urandom_range(0, 31));
            a_prio  = 4'($urandom_range(0, 15));
            a_clr   = $urandom_range(0, 7) == 0;
            b_upt   = $urandom_range(0, 2) != 0;
            b_id    = 5'($urandom_range(0, 31));
            b_prio  = 4'($urandom_range(0, 15));
            b_clr   = $urandom_range(0, 7) == 0;
            b_epoch = $urandom_range(0, 5) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
